// File: rtl/cnn_host_sequencer_if.sv
// Port bundles for cnn_host_sequencer: upstream byte stream, engine load/start
// control, and result return. The master side drives valid/data.
interface cnn_host_stream_if;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic [1:0] s_mode;

  modport master (output s_valid, s_data, s_mode, input s_ready);
  modport slave  (input s_valid, s_data, s_mode, output s_ready);
endinterface

interface cnn_host_engine_if;
  logic [7:0]  cnn_data_in;
  logic        cnn_load_enable;
  logic        cnn_start_operation;
  logic [1:0]  cnn_mode_select;
  logic [31:0] cnn_result_out;
  logic        cnn_busy;
  logic        cnn_overflow_flag;

  modport master (output cnn_data_in, cnn_load_enable, cnn_start_operation, cnn_mode_select,
                  input  cnn_result_out, cnn_busy, cnn_overflow_flag);
  modport slave  (input  cnn_data_in, cnn_load_enable, cnn_start_operation, cnn_mode_select,
                  output cnn_result_out, cnn_busy, cnn_overflow_flag);
endinterface

interface cnn_host_result_if;
  logic        r_valid;
  logic        r_ready;
  logic [31:0] r_data;
  logic        r_overflow;

  modport master (output r_valid, r_data, r_overflow, input r_ready);
  modport slave  (input r_valid, r_data, r_overflow, output r_ready);
endinterface

// File: rtl/cnn_host_sequencer.sv
// Buffers one 2*WINDOW^2-byte frame, replays it to the CNN engine as a single
// gap-free load burst, starts the engine and returns its result on r_*.
module cnn_host_sequencer #(
  parameter int WINDOW       = 5,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic              clk,
  input  logic              reset,
  cnn_host_stream_if.slave  s,
  cnn_host_engine_if.master eng,
  cnn_host_result_if.master r,
  output logic [15:0]       frame_count
);
  localparam int NN       = WINDOW * WINDOW;
  localparam int MEM_SIZE = 2 * NN;
  localparam int PTR_W    = $clog2(MEM_SIZE + 1);
  localparam int IDX_W    = $clog2(MEM_SIZE);
  localparam int TMR_W    = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

  localparam logic [3:0] ST_FILL      = 4'd0;
  localparam logic [3:0] ST_PRE       = 4'd1;
  localparam logic [3:0] ST_STREAM    = 4'd2;
  localparam logic [3:0] ST_LOAD_WAIT = 4'd3;
  localparam logic [3:0] ST_IDLE      = 4'd4;
  localparam logic [3:0] ST_START     = 4'd5;
  localparam logic [3:0] ST_WAIT_HI   = 4'd6;
  localparam logic [3:0] ST_WAIT_LO   = 4'd7;
  localparam logic [3:0] ST_CAPTURE   = 4'd8;
  localparam logic [3:0] ST_RESULT    = 4'd9;

  logic [3:0]       state_reg, state_next;
  logic [PTR_W-1:0] wptr_reg, rptr_reg;
  logic [TMR_W-1:0] timer_reg;
  logic [1:0]       mode_q_reg, mode_sel_reg;
  logic [7:0]       data_reg;
  logic             load_en_reg, start_reg;
  logic [31:0]      r_data_reg;
  logic             r_ovf_reg;
  logic [15:0]      frame_count_reg;
  logic [7:0]       frame_mem [MEM_SIZE];

  logic accept, last_byte, stream_done, timeout_hit;

  assign accept      = (state_reg == ST_FILL) && s.s_valid;
  assign last_byte   = (wptr_reg == PTR_W'(MEM_SIZE - 1));
  assign stream_done = (rptr_reg == PTR_W'(MEM_SIZE));
  assign timeout_hit = (timer_reg == TMR_W'(BUSY_TIMEOUT - 1));

  // Single frame buffer: written only while filling, read only while streaming.
  always_ff @(posedge clk) begin
    if (accept) begin
      frame_mem[wptr_reg[IDX_W-1:0]] <= s.s_data;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_FILL:      if (accept && last_byte) state_next = ST_PRE;
      ST_PRE:       state_next = ST_STREAM;
      ST_STREAM:    if (stream_done) state_next = ST_LOAD_WAIT;
      ST_LOAD_WAIT: if (!eng.cnn_busy) state_next = ST_IDLE;
      ST_IDLE:      state_next = ST_START;
      ST_START:     state_next = ST_WAIT_HI;
      ST_WAIT_HI: begin
        // An engine that finishes without ever raising busy is released by the timer.
        if (eng.cnn_busy)     state_next = ST_WAIT_LO;
        else if (timeout_hit) state_next = ST_CAPTURE;
      end
      ST_WAIT_LO:   if (!eng.cnn_busy) state_next = ST_CAPTURE;
      ST_CAPTURE:   state_next = ST_RESULT;
      ST_RESULT:    if (r.r_ready) state_next = ST_FILL;
      default:      state_next = ST_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= ST_FILL;
      wptr_reg        <= '0;
      rptr_reg        <= '0;
      timer_reg       <= '0;
      mode_q_reg      <= 2'b00;
      mode_sel_reg    <= 2'b00;
      data_reg        <= 8'h00;
      load_en_reg     <= 1'b0;
      start_reg       <= 1'b0;
      r_data_reg      <= 32'h0;
      r_ovf_reg       <= 1'b0;
      frame_count_reg <= 16'h0;
    end else begin
      state_reg   <= state_next;
      load_en_reg <= 1'b0;
      start_reg   <= 1'b0;
      case (state_reg)
        ST_FILL: begin
          if (accept) begin
            wptr_reg <= wptr_reg + PTR_W'(1);
            if (wptr_reg == '0) mode_q_reg <= s.s_mode;
            if (last_byte) begin
              // Next cycle is the setup beat: load strobe high with a zero byte.
              load_en_reg <= 1'b1;
              data_reg    <= 8'h00;
              rptr_reg    <= '0;
            end
          end
        end
        ST_PRE: begin
          load_en_reg <= 1'b1;
          data_reg    <= frame_mem[rptr_reg[IDX_W-1:0]];
          rptr_reg    <= rptr_reg + PTR_W'(1);
        end
        ST_STREAM: begin
          if (stream_done) begin
            data_reg     <= 8'h00;
            mode_sel_reg <= mode_q_reg;
          end else begin
            load_en_reg <= 1'b1;
            data_reg    <= frame_mem[rptr_reg[IDX_W-1:0]];
            rptr_reg    <= rptr_reg + PTR_W'(1);
          end
        end
        ST_IDLE: begin
          start_reg <= 1'b1;
          timer_reg <= '0;
        end
        ST_START: timer_reg <= '0;
        ST_WAIT_HI: begin
          if (!eng.cnn_busy && !timeout_hit) timer_reg <= timer_reg + TMR_W'(1);
        end
        ST_CAPTURE: begin
          r_data_reg      <= eng.cnn_result_out;
          r_ovf_reg       <= eng.cnn_overflow_flag;
          frame_count_reg <= frame_count_reg + 16'd1;
          wptr_reg        <= '0;
          mode_sel_reg    <= 2'b00;
        end
        default: ;
      endcase
    end
  end

  assign s.s_ready               = (state_reg == ST_FILL);
  assign eng.cnn_data_in         = data_reg;
  assign eng.cnn_load_enable     = load_en_reg;
  assign eng.cnn_start_operation = start_reg;
  assign eng.cnn_mode_select     = mode_sel_reg;
  assign r.r_valid               = (state_reg == ST_RESULT);
  assign r.r_data                = r_data_reg;
  assign r.r_overflow            = r_ovf_reg;
  assign frame_count             = frame_count_reg;
endmodule

// File: tb/tb_cnn_host_sequencer.sv
// Self-checking bench for cnn_host_sequencer with a behavioural CNN engine model.
`timescale 1ns/1ps
module tb_cnn_host_sequencer;
  localparam int WINDOW = 5;
  localparam int NN     = WINDOW * WINDOW;
  localparam int MEM    = 2 * NN;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] frame_count;

  cnn_host_stream_if s_if ();
  cnn_host_engine_if e_if ();
  cnn_host_result_if r_if ();

  cnn_host_sequencer #(.WINDOW(WINDOW), .BUSY_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .s(s_if), .eng(e_if), .r(r_if), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  logic [7:0] frame [MEM];

  // Engine behaviour: MAC = sum(a*w), ReLU = max(0, MAC), MaxPool = max activation,
  // reserved mode treated as MAC.
  function automatic logic [31:0] engine_fn(input logic [1:0] mode, input logic [7:0] b [MEM]);
    int acc = 0;
    int mx = -128;
    for (int i = 0; i < NN; i++) begin
      acc += int'($signed(b[i])) * int'($signed(b[NN+i]));
      if (int'($signed(b[i])) > mx) mx = int'($signed(b[i]));
    end
    case (mode)
      2'b01:   return (acc < 0) ? 32'd0 : 32'(acc);
      2'b10:   return 32'(mx);
      default: return 32'(acc);
    endcase
  endfunction

  // Engine model: records load bursts and start pulses, raises busy the cycle after start.
  logic [7:0]  ld_bytes [MEM];
  int          ld_cnt, last_burst, n_bursts, n_starts, start_gap, gap_cnt, busy_left;
  int          busy_len = 3;
  bit          no_busy = 0, force_ovf = 0;
  logic [1:0]  start_mode;
  logic [31:0] pend_res;

  always @(posedge clk) begin
    if (reset) begin
      ld_cnt <= 0; last_burst <= 0; n_bursts <= 0; n_starts <= 0;
      start_gap <= 0; gap_cnt <= 0; busy_left <= 0; start_mode <= 2'b00; pend_res <= 32'h0;
      e_if.cnn_busy <= 1'b0; e_if.cnn_result_out <= 32'h0; e_if.cnn_overflow_flag <= 1'b0;
    end else begin
      if (e_if.cnn_load_enable) begin
        if (ld_cnt >= 1 && ld_cnt <= MEM) ld_bytes[ld_cnt-1] <= e_if.cnn_data_in;
        ld_cnt  <= ld_cnt + 1;
        gap_cnt <= 0;
      end else begin
        if (ld_cnt != 0) begin
          last_burst <= ld_cnt;
          n_bursts   <= n_bursts + 1;
          ld_cnt     <= 0;
        end
        if (!e_if.cnn_start_operation) gap_cnt <= gap_cnt + 1;
      end
      if (e_if.cnn_start_operation) begin
        n_starts   <= n_starts + 1;
        start_mode <= e_if.cnn_mode_select;
        start_gap  <= gap_cnt;
        if (no_busy) begin
          e_if.cnn_result_out    <= engine_fn(e_if.cnn_mode_select, ld_bytes);
          e_if.cnn_overflow_flag <= force_ovf;
        end else begin
          pend_res      <= engine_fn(e_if.cnn_mode_select, ld_bytes);
          e_if.cnn_busy <= 1'b1;
          busy_left     <= busy_len;
        end
      end else if (e_if.cnn_busy) begin
        if (busy_left <= 1) begin
          e_if.cnn_busy          <= 1'b0;
          e_if.cnn_result_out    <= pend_res;
          e_if.cnn_overflow_flag <= force_ovf;
        end else begin
          busy_left <= busy_left - 1;
        end
      end
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1; s_if.s_valid = 1'b0; r_if.r_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Streams frame[] (mode only on the first byte) and waits for r_valid.
  task automatic send_frame(input logic [1:0] mode, input bit gaps, output bit ok);
    int idx = 0, cyc = 0, gap_left = 0;
    while (idx < MEM && cyc < 3000) begin
      @(negedge clk); cyc++;
      if (gap_left > 0) begin
        s_if.s_valid = 1'b0; s_if.s_mode = 2'($urandom); gap_left--;
      end else begin
        s_if.s_valid = 1'b1;
        s_if.s_data  = frame[idx];
        s_if.s_mode  = (idx == 0) ? mode : 2'($urandom);
        if (s_if.s_ready) begin
          idx++;
          if (gaps) gap_left = $urandom_range(0, 3);
        end
      end
    end
    @(negedge clk);
    s_if.s_valid = 1'b0;
    ok = (idx == MEM);
  endtask

  task automatic do_frame(input logic [1:0] mode, input bit gaps, output bit ok,
                          output logic [31:0] d, output logic o, output logic [15:0] fc);
    int cyc = 0;
    bit sent;
    send_frame(mode, gaps, sent);
    while (r_if.r_valid !== 1'b1 && cyc < 500) begin @(negedge clk); cyc++; end
    ok = sent && (r_if.r_valid === 1'b1);
    d = r_if.r_data; o = r_if.r_overflow; fc = frame_count;
  endtask

  task automatic release_result(output logic sr, output logic rv);
    @(negedge clk); r_if.r_ready = 1'b1;
    @(negedge clk); r_if.r_ready = 1'b0;
    sr = s_if.s_ready; rv = r_if.r_valid;
  endtask

  task automatic test_reset();
    s_if.s_valid = 1'b0; s_if.s_data = 8'h00; s_if.s_mode = 2'b00; r_if.r_ready = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (s_if.s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready: got %b want 1", s_if.s_ready); end
    vectors++;
    if ({e_if.cnn_load_enable, e_if.cnn_start_operation, e_if.cnn_data_in, e_if.cnn_mode_select} !== 12'h0) begin
      errors++; $display("FAIL reset_engine_outs: got %h want 000",
        {e_if.cnn_load_enable, e_if.cnn_start_operation, e_if.cnn_data_in, e_if.cnn_mode_select});
    end
    vectors++;
    if ({r_if.r_valid, r_if.r_overflow, r_if.r_data} !== 34'h0) begin
      errors++; $display("FAIL reset_result_outs: got valid=%b ovf=%b data=%h want 0", r_if.r_valid, r_if.r_overflow, r_if.r_data);
    end
    vectors++;
    if (frame_count !== 16'h0) begin errors++; $display("FAIL reset_frame_count: got %0d want 0", frame_count); end
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (s_if.s_ready !== 1'b1) begin errors++; $display("FAIL post_reset_s_ready: got %b want 1", s_if.s_ready); end
  endtask

  task automatic fill_mac();
    for (int i = 0; i < NN; i++) begin frame[i] = 8'(i + 1); frame[NN+i] = 8'd1; end
  endtask

  task automatic test_reset_mid_stream();
    bit ok; logic [31:0] d; logic o; logic [15:0] fc; logic sr, rv; int cyc = 0;
    fill_mac(); no_busy = 0; force_ovf = 0; busy_len = 2;
    send_frame(2'b00, 0, ok);
    while (ld_cnt < 11 && cyc < 200) begin @(negedge clk); cyc++; end
    vectors++;
    if (ld_cnt != 11) begin errors++; $display("FAIL mid_reset_reach_byte10: got %0d load cycles want 11", ld_cnt); end
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (e_if.cnn_load_enable !== 1'b0) begin errors++; $display("FAIL mid_reset_load_enable: got %b want 0", e_if.cnn_load_enable); end
    vectors++;
    if (s_if.s_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_s_ready: got %b want 1", s_if.s_ready); end
    vectors++;
    if (frame_count !== 16'd0) begin errors++; $display("FAIL mid_reset_frame_count: got %0d want 0", frame_count); end
    reset = 1'b0;
    do_frame(2'b00, 0, ok, d, o, fc);
    vectors++;
    if (!ok || d !== 32'd325) begin errors++; $display("FAIL mid_reset_fresh_mac: ok=%b got %0d want 325", ok, d); end
    vectors++;
    if (fc !== 16'd1) begin errors++; $display("FAIL mid_reset_fresh_count: got %0d want 1", fc); end
    release_result(sr, rv);
  endtask

  task automatic test_maxpool();
    bit ok; logic [31:0] d; logic o; logic [15:0] fc; logic sr, rv;
    apply_reset();
    for (int i = 0; i < NN; i++) begin frame[i] = 8'(i + 1); frame[NN+i] = 8'd1; end
    no_busy = 0; force_ovf = 0; busy_len = 3;
    do_frame(2'b10, 0, ok, d, o, fc);
    vectors++;
    if (!ok) begin errors++; $display("FAIL maxpool_done: result never became valid"); end
    vectors++;
    if (last_burst != MEM + 1 || n_bursts != 1) begin
      errors++; $display("FAIL maxpool_load_burst: got len=%0d bursts=%0d want len=51 bursts=1", last_burst, n_bursts);
    end
    vectors++;
    if (n_starts != 1 || start_mode !== 2'b10) begin
      errors++; $display("FAIL maxpool_start: got starts=%0d mode=%b want 1/10", n_starts, start_mode);
    end
    vectors++;
    if (start_gap != 2) begin errors++; $display("FAIL maxpool_start_gap: got %0d idle cycles want 2", start_gap); end
    vectors++;
    if (d !== 32'd25 || o !== 1'b0) begin errors++; $display("FAIL maxpool_result: got %0d ovf=%b want 25 ovf=0", d, o); end
    vectors++;
    if (fc !== 16'd1) begin errors++; $display("FAIL maxpool_frame_count: got %0d want 1", fc); end
    release_result(sr, rv);
    vectors++;
    if (sr !== 1'b1 || rv !== 1'b0) begin errors++; $display("FAIL maxpool_handshake: got s_ready=%b r_valid=%b want 1/0", sr, rv); end
  endtask

  task automatic test_relu();
    bit ok; logic [31:0] d; logic o; logic [15:0] fc; logic sr, rv;
    for (int i = 0; i < NN; i++) begin frame[i] = (i < 12) ? 8'hFB : 8'd5; frame[NN+i] = 8'd1; end
    no_busy = 0; force_ovf = 0; busy_len = 5;
    do_frame(2'b01, 0, ok, d, o, fc);
    vectors++;
    if (!ok || d !== 32'd5 || o !== 1'b0) begin errors++; $display("FAIL relu_result: ok=%b got %0d ovf=%b want 5 ovf=0", ok, d, o); end
    vectors++;
    if (fc !== 16'd2) begin errors++; $display("FAIL relu_frame_count: got %0d want 2", fc); end
    release_result(sr, rv);
  endtask

  task automatic test_mac_gaps();
    bit ok; logic [31:0] d; logic o; logic [15:0] fc; logic sr, rv; int b0;
    fill_mac(); no_busy = 0; force_ovf = 0; busy_len = 1;
    b0 = n_bursts;
    do_frame(2'b00, 1, ok, d, o, fc);
    vectors++;
    if (!ok || d !== 32'd325) begin errors++; $display("FAIL mac_gaps_result: ok=%b got %0d want 325", ok, d); end
    vectors++;
    if (last_burst != MEM + 1 || n_bursts != b0 + 1) begin
      errors++; $display("FAIL mac_gaps_contiguous: got len=%0d bursts=%0d want len=51 bursts=1", last_burst, n_bursts - b0);
    end
    release_result(sr, rv);
  endtask

  task automatic test_overflow();
    bit ok; logic [31:0] d; logic o; logic [15:0] fc; logic sr, rv;
    for (int i = 0; i < MEM; i++) frame[i] = 8'd120;
    no_busy = 0; force_ovf = 1; busy_len = 4;
    do_frame(2'b00, 0, ok, d, o, fc);
    vectors++;
    if (!ok || d !== 32'd360000 || o !== 1'b1) begin
      errors++; $display("FAIL overflow_passthrough: ok=%b got %0d ovf=%b want 360000 ovf=1", ok, d, o);
    end
    force_ovf = 0;
    release_result(sr, rv);
  endtask

  task automatic test_backpressure();
    bit ok; logic [31:0] d, exp; logic o; logic [15:0] fc; logic [1:0] m;
    fill_mac(); no_busy = 0; busy_len = 2;
    do_frame(2'b00, 0, ok, d, o, fc);
    vectors++;
    if (!ok || d !== 32'd325) begin errors++; $display("FAIL backpressure_first: ok=%b got %0d want 325", ok, d); end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      s_if.s_valid = 1'b1; s_if.s_data = 8'($urandom);
      vectors++;
      if (r_if.r_valid !== 1'b1 || s_if.s_ready !== 1'b0 || r_if.r_data !== 32'd325) begin
        errors++; $display("FAIL backpressure_hold_%0d: got r_valid=%b s_ready=%b r_data=%0d want 1/0/325",
          c, r_if.r_valid, s_if.s_ready, r_if.r_data);
      end
    end
    @(negedge clk); r_if.r_ready = 1'b1;
    @(negedge clk); r_if.r_ready = 1'b0; s_if.s_valid = 1'b0;
    vectors++;
    if (s_if.s_ready !== 1'b1 || r_if.r_valid !== 1'b0) begin
      errors++; $display("FAIL backpressure_release: got s_ready=%b r_valid=%b want 1/0", s_if.s_ready, r_if.r_valid);
    end
    // Nothing offered during RESULT may have been written: the next frame must be exact.
    for (int i = 0; i < MEM; i++) frame[i] = 8'($urandom);
    m = 2'b01; exp = engine_fn(m, frame);
    do_frame(m, 0, ok, d, o, fc);
    vectors++;
    if (!ok || d !== exp) begin errors++; $display("FAIL backpressure_next_frame: ok=%b got %h want %h", ok, d, exp); end
    release_result(o, o);
  endtask

  task automatic test_busy_timeout();
    bit ok; logic [31:0] d, exp; logic o; logic [15:0] fc; logic sr, rv; int s0;
    for (int i = 0; i < MEM; i++) frame[i] = 8'($urandom);
    exp = engine_fn(2'b00, frame);
    no_busy = 1; force_ovf = 0; s0 = n_starts;
    do_frame(2'b00, 0, ok, d, o, fc);
    vectors++;
    if (!ok || d !== exp || n_starts != s0 + 1) begin
      errors++; $display("FAIL busy_timeout: ok=%b got %h starts=%0d want %h starts=1", ok, d, n_starts - s0, exp);
    end
    no_busy = 0;
    release_result(sr, rv);
  endtask

  task automatic test_random(input int n);
    bit ok; logic [31:0] d, exp; logic o; logic [15:0] fc, exp_fc; logic sr, rv; logic [1:0] m; int s0;
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < MEM; i++) frame[i] = 8'($urandom);
      m = 2'($urandom); exp = engine_fn(m, frame);
      no_busy = ($urandom_range(0, 3) == 0); force_ovf = $urandom_range(0, 1); busy_len = $urandom_range(1, 8);
      s0 = n_starts; exp_fc = frame_count + 16'd1;
      do_frame(m, $urandom_range(0, 1), ok, d, o, fc);
      vectors++;
      if (!ok || d !== exp || o !== force_ovf || fc !== exp_fc) begin
        errors++; $display("FAIL random_%0d: ok=%b got data=%h ovf=%b cnt=%0d want data=%h ovf=%b cnt=%0d",
          k, ok, d, o, fc, exp, force_ovf, exp_fc);
      end
      vectors++;
      if (n_starts != s0 + 1 || start_mode !== m || last_burst != MEM + 1) begin
        errors++; $display("FAIL random_engine_%0d: got starts=%0d mode=%b burst=%0d want 1/%b/51",
          k, n_starts - s0, start_mode, last_burst, m);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      release_result(sr, rv);
      vectors++;
      if (sr !== 1'b1 || rv !== 1'b0) begin errors++; $display("FAIL random_handshake_%0d: got s_ready=%b r_valid=%b want 1/0", k, sr, rv); end
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_stream();
    test_maxpool();
    test_relu();
    test_mac_gaps();
    test_overflow();
    test_backpressure();
    test_busy_timeout();
    test_random(20);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
